// File: rtl/imuldiv_int_div_iterative.sv
// Iterative 32-bit integer divider: one restoring step per cycle, signed or unsigned,
// with valid/ready handshakes on the request and response sides.
module imuldiv_int_div_iterative (
  input  logic        clk,
  input  logic        reset,
  input  logic        divreq_msg_fn,
  input  logic [31:0] divreq_msg_a,
  input  logic [31:0] divreq_msg_b,
  input  logic        divreq_val,
  output logic        divreq_rdy,
  output logic [63:0] divresp_msg_result,
  output logic        divresp_val,
  input  logic        divresp_rdy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q;
  logic        rdy_q;
  logic        val_q;

  logic [64:0] rq_q, rq_d;
  logic [31:0] b_mag_q, b_mag_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic        div0_q, div0_d;

  logic        accept;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [33:0] diff;
  logic [31:0] quot;
  logic [31:0] rem;

  assign accept = divreq_val && rdy_q;

  // NOTE: sequential state is written only with <= so every register samples
  // pre-edge values, independent of statement order inside the block.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rdy_q   <= 1'b1;
      val_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= CALC;
            rdy_q   <= 1'b0;
          end
        end
        CALC: begin
          if (cnt_q == 5'd0) begin
            state_q <= DONE;
            val_q   <= 1'b1;
          end
        end
        DONE: begin
          if (divresp_rdy) begin
            state_q <= IDLE;
            val_q   <= 1'b0;
            rdy_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          rdy_q   <= 1'b1;
          val_q   <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: every signal driven here gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    a_mag   = (divreq_msg_fn && divreq_msg_a[31]) ? -divreq_msg_a : divreq_msg_a;
    b_mag   = (divreq_msg_fn && divreq_msg_b[31]) ? -divreq_msg_b : divreq_msg_b;
    // Shifted partial remainder includes the bit shifted out of the top, so the
    // compare is exact even though that bit is always zero in practice.
    diff    = rq_q[64:31] - {2'b00, b_mag_q};
    rq_d    = rq_q;
    b_mag_d = b_mag_q;
    cnt_d   = cnt_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    div0_d  = div0_q;
    if (accept) begin
      rq_d    = {33'd0, a_mag};
      b_mag_d = b_mag;
      cnt_d   = 5'd31;
      q_neg_d = divreq_msg_fn & (divreq_msg_a[31] ^ divreq_msg_b[31]);
      r_neg_d = divreq_msg_fn & divreq_msg_a[31];
      div0_d  = (divreq_msg_b == 32'd0);
    end else if (state_q == CALC) begin
      cnt_d = cnt_q - 5'd1;
      if (!diff[33]) begin
        rq_d = {diff[32:0], rq_q[30:0], 1'b1};
      end else begin
        rq_d = {rq_q[63:0], 1'b0};
      end
    end
  end

  // NOTE: datapath registers carry no reset; they are always loaded on accept
  // before the FSM ever looks at them, so only the control state is reset.
  always_ff @(posedge clk) begin
    rq_q    <= rq_d;
    b_mag_q <= b_mag_d;
    cnt_q   <= cnt_d;
    q_neg_q <= q_neg_d;
    r_neg_q <= r_neg_d;
    div0_q  <= div0_d;
  end

  // A zero divisor leaves an all-ones magnitude; the sign fix-up is skipped so the
  // quotient reads 0xFFFFFFFF regardless of operand signs.
  assign quot = div0_q  ? 32'hFFFF_FFFF
              : q_neg_q ? -rq_q[31:0] : rq_q[31:0];
  assign rem  = r_neg_q ? -rq_q[63:32] : rq_q[63:32];

  assign divresp_msg_result = {rem, quot};
  assign divreq_rdy         = rdy_q;
  assign divresp_val        = val_q;

endmodule

// File: tb/tb_imuldiv_int_div_iterative.sv
// Scoreboard bench for the iterative divider: expected results are queued on
// accept and compared when the response appears.
module tb_imuldiv_int_div_iterative;

  logic        clk = 1'b0;
  logic        reset;
  logic        divreq_msg_fn;
  logic [31:0] divreq_msg_a;
  logic [31:0] divreq_msg_b;
  logic        divreq_val;
  logic        divreq_rdy;
  logic [63:0] divresp_msg_result;
  logic        divresp_val;
  logic        divresp_rdy;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  imuldiv_int_div_iterative dut (
    .clk                (clk),
    .reset              (reset),
    .divreq_msg_fn      (divreq_msg_fn),
    .divreq_msg_a       (divreq_msg_a),
    .divreq_msg_b       (divreq_msg_b),
    .divreq_val         (divreq_val),
    .divreq_rdy         (divreq_rdy),
    .divresp_msg_result (divresp_msg_result),
    .divresp_val        (divresp_val),
    .divresp_rdy        (divresp_rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: C-style truncating division, plus the divide-by-zero and overflow rules.
  function automatic logic [63:0] model(input logic fn, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    logic [31:0] q, r;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (fn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (fn) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_exp(input logic fn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, output int waited);
    waited        = 0;
    divreq_msg_fn = fn;
    divreq_msg_a  = a;
    divreq_msg_b  = b;
    divreq_val    = 1'b1;
    while (!divreq_rdy && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("req_rdy", divreq_rdy, 1'b1);
    @(posedge clk);
    exp_q.push_back(exp);
    @(negedge clk);
    divreq_val   = 1'b0;
    divreq_msg_a = $urandom;
    divreq_msg_b = $urandom;
  endtask

  task automatic send(input logic fn, input logic [31:0] a, input logic [31:0] b, output int waited);
    send_exp(fn, a, b, model(fn, a, b), waited);
  endtask

  task automatic recv(input string tag, input int stall, input bit hold_val);
    int          cyc;
    bit          rdy_seen;
    logic [63:0] exp;
    cyc      = 0;
    rdy_seen = 1'b0;
    if (hold_val) begin
      divreq_val    = 1'b1;
      divreq_msg_fn = 1'b1;
      divreq_msg_a  = $urandom;
      divreq_msg_b  = $urandom;
    end
    while (!divresp_val && cyc < 100) begin
      if (divreq_rdy) rdy_seen = 1'b1;
      @(negedge clk);
      cyc++;
    end
    divreq_val = 1'b0;
    // 32 negedges after the accept edge means the response is seen at edge N+33.
    check({tag, " latency"}, cyc, 32);
    check({tag, " calc_rdy"}, rdy_seen, 1'b0);
    check({tag, " sb_size"}, exp_q.size(), 1);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 64'h0;
    check({tag, " result"}, divresp_msg_result, exp);
    check({tag, " done_rdy"}, divreq_rdy, 1'b0);
    if (stall > 0) begin
      divresp_rdy = 1'b0;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        check({tag, " stall_val"}, divresp_val, 1'b1);
        check({tag, " stall_result"}, divresp_msg_result, exp);
        check({tag, " stall_rdy"}, divreq_rdy, 1'b0);
      end
      divresp_rdy = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check({tag, " idle"}, {divresp_val, divreq_rdy}, 2'b01);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int seen;
    logic        fn;
    logic [31:0] a, b;

    reset         = 1'b1;
    divreq_val    = 1'b0;
    divreq_msg_fn = 1'b0;
    divreq_msg_a  = '0;
    divreq_msg_b  = '0;
    divresp_rdy   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset rdy_val", {divresp_val, divreq_rdy}, 2'b01);

    send_exp(1'b1, 32'd7, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, w);
    recv("signed", 0, 1'b0);
    send_exp(1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 64'h0000000F_0FFFFFFF, w);
    recv("unsigned", 0, 1'b1);
    send_exp(1'b1, 32'hFFFF_FFFB, 32'd0, 64'hFFFFFFFB_FFFFFFFF, w);
    recv("div0_s", 0, 1'b0);
    send_exp(1'b0, 32'hFFFF_FFFB, 32'd0, 64'hFFFFFFFB_FFFFFFFF, w);
    recv("div0_u", 0, 1'b0);
    send_exp(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, w);
    recv("overflow", 0, 1'b0);
    send(1'b1, 32'hFFFF_FFF9, 32'd2, w);
    recv("neg_div", 0, 1'b0);
    send(1'b0, 32'd3, 32'd7, w);
    recv("a_lt_b", 0, 1'b0);

    send(1'b1, 32'd100, 32'hFFFF_FFF9, w);
    recv("bp", 5, 1'b0);
    send(1'b0, 32'd1000, 32'd3, w);
    check("b2b accept_wait", w, 0);
    recv("b2b", 0, 1'b0);

    send(1'b1, 32'hFFFF_FF9C, 32'd7, w);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    check("rst_mid rdy_val", {divresp_val, divreq_rdy}, 2'b01);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (divresp_val) seen++;
    end
    check("rst_mid no_resp", seen, 0);
    send(1'b1, 32'hFFFF_FF9C, 32'd7, w);
    recv("after_rst", 0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      fn = 1'($urandom_range(0, 1));
      a  = $urandom;
      b  = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) b = -b;
      if (i == 5) b = 32'd0;
      send(fn, a, b, w);
      recv($sformatf("rand%0d", i), (i == 7) ? 2 : 0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
